// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the fetch/LSU memory-port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t;
  typedef enum logic {GRANT_INS, GRANT_LS} arb_grant_t;

  // Memory command as latched at grant time and held on the port until ack.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
  } mem_cmd_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The arbiter takes the
// master modport; requesters and memory (or a bench) take the slave modport.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              ins_req;
  logic [ADDR_W-1:0] ins_addr;
  logic              ins_cancel;
  logic              ins_res;
  logic [DATA_W-1:0] ins_data;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [3:0]        ls_wstrb;
  logic              ls_res;
  logic [DATA_W-1:0] ls_data;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ins_req, ins_addr, ins_cancel, ls_req, ls_we, ls_addr, ls_wdata,
           ls_wstrb, mem_ack, mem_rdata,
    output ins_res, ins_data, ls_res, ls_data, mem_req, mem_we, mem_addr,
           mem_wdata, mem_wstrb
  );

  modport slave (
    output ins_req, ins_addr, ins_cancel, ls_req, ls_we, ls_addr, ls_wdata,
           ls_wstrb, mem_ack, mem_rdata,
    input  ins_res, ins_data, ls_res, ls_data, mem_req, mem_we, mem_addr,
           mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection. MEM_ARB_RR_EN selects round-robin on
// conflict; otherwise the LSU has fixed priority over fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ins_req,
  input  logic       ls_req,
  input  arb_grant_t last,
  output logic       any,
  output arb_grant_t winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    any    = ins_req | ls_req;
    winner = GRANT_INS;
    if (ins_req && ls_req) winner = (last == GRANT_INS) ? GRANT_LS : GRANT_INS;
    else if (ls_req)       winner = GRANT_LS;
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    any    = ins_req | ls_req;
    winner = ls_req ? GRANT_LS : GRANT_INS;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/LSU) arbiter for the shared memory port.
// Build option: MEM_ARB_RR_EN enables round-robin conflict resolution.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input logic           cpu_clk,
  input logic           cpu_rst,
  mem_arbiter_if.master bus
);

  arb_state_t        state, state_nxt;
  arb_grant_t        grant, winner;
  logic              any;
  logic              cancel;
  mem_cmd_t          cmd;
  logic [DATA_W-1:0] ins_data, ls_data;

  mem_arb_pick u_pick (
    .ins_req (bus.ins_req),
    .ls_req  (bus.ls_req),
    .last    (grant),
    .any     (any),
    .winner  (winner)
  );

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any) state_nxt = WAIT;
      WAIT:    if (bus.mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from the registered state, so reset clears them at once.
  always_comb begin
    bus.mem_req = (state == WAIT);
    bus.ins_res = (state == RESP) && (grant == GRANT_INS) && !cancel;
    bus.ls_res  = (state == RESP) && (grant == GRANT_LS);
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      grant    <= GRANT_INS;
      cancel   <= 1'b0;
      cmd      <= '0;
      ins_data <= '0;
      ls_data  <= '0;
    end else begin
      unique case (state)
        IDLE: if (any) begin
          grant  <= winner;
          cancel <= (winner == GRANT_INS) && bus.ins_cancel;
          if (winner == GRANT_LS)
            cmd <= '{we: bus.ls_we, addr: bus.ls_addr, wdata: bus.ls_wdata,
                     wstrb: bus.ls_wstrb};
          else
            cmd <= '{we: 1'b0, addr: bus.ins_addr, wdata: '0, wstrb: 4'b0};
        end
        WAIT: begin
          if (grant == GRANT_INS && bus.ins_cancel) cancel <= 1'b1;
          // A cancelled fetch still captures data; only its pulse is dropped.
          if (bus.mem_ack) begin
            if (grant == GRANT_INS)  ins_data <= bus.mem_rdata;
            else if (!cmd.we)        ls_data  <= bus.mem_rdata;
          end
        end
        RESP:    cancel <= 1'b0;
        default: cancel <= 1'b0;
      endcase
    end
  end

  assign bus.mem_we    = cmd.we;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;
  assign bus.mem_wstrb = cmd.wstrb;
  assign bus.ins_data  = ins_data;
  assign bus.ls_data   = ls_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus hand sequences for
// arbitration order, cancel, reset mid-access and spurious acknowledge.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  mem_arbiter_if bus();

  mem_arbiter dut (.cpu_clk(clk), .cpu_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_ins, exp_ls;

  typedef struct {
    bit          ls;
    bit          we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_n;
    logic [31:0] rdata;
    bit          exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ins_req = 1'b0; bus.ins_addr = '0; bus.ins_cancel = 1'b0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0;
    bus.ls_wdata = '0; bus.ls_wstrb = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ins = '0; exp_ls = '0;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    chk({name, "_res"}, 32'({bus.ins_res, bus.ls_res}), 32'd0);
  endtask

  // Called at #1 into an IDLE cycle; returns at #1 into the next IDLE cycle.
  task automatic do_txn(input vec_t v);
    if (v.ls) begin
      bus.ls_req = 1'b1; bus.ls_we = v.we; bus.ls_addr = v.addr;
      bus.ls_wdata = v.wdata; bus.ls_wstrb = v.wstrb;
    end else begin
      bus.ins_req = 1'b1; bus.ins_addr = v.addr;
    end
    @(posedge clk); #1;
    chk("txn_mem_req", 32'(bus.mem_req), 32'd1);
    chk("txn_mem_addr", 32'(bus.mem_addr), 32'(v.addr));
    chk("txn_mem_we", 32'(bus.mem_we), 32'(v.exp_we));
    chk("txn_mem_wstrb", 32'(bus.mem_wstrb), 32'(v.exp_wstrb));
    if (v.ls && v.we) chk("txn_mem_wdata", bus.mem_wdata, v.wdata);
    for (int i = 0; i < v.wait_n; i++) begin
      @(posedge clk); #1;
      chk("wait_mem_req", 32'(bus.mem_req), 32'd1);
      chk("wait_no_res", 32'({bus.ins_res, bus.ls_res}), 32'd0);
      chk("wait_fields", {bus.mem_addr, bus.mem_we, bus.mem_wstrb[0]},
          {v.addr, v.exp_we, v.exp_wstrb[0]});
      if (v.ls && v.we) chk("wait_wdata", bus.mem_wdata, v.wdata);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = v.rdata;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    chk("resp_ins_res", 32'(bus.ins_res), 32'(!v.ls));
    chk("resp_ls_res", 32'(bus.ls_res), 32'(v.ls));
    chk("resp_mem_req", 32'(bus.mem_req), 32'd0);
    if (v.ls) begin
      exp_ls = v.exp_data;
      chk("resp_ls_data", bus.ls_data, exp_ls);
      chk("held_ins_data", bus.ins_data, exp_ins);
    end else begin
      exp_ins = v.exp_data;
      chk("resp_ins_data", bus.ins_data, exp_ins);
      chk("held_ls_data", bus.ls_data, exp_ls);
    end
    @(posedge clk); #1;
    bus.ins_req = 1'b0; bus.ls_req = 1'b0;
    chk("pulse_one_cycle", 32'({bus.ins_res, bus.ls_res}), 32'd0);
    chk("after_ins_data", bus.ins_data, exp_ins);
    chk("after_ls_data", bus.ls_data, exp_ls);
  endtask

  initial begin
    bit exp_order[4];
    int ls_left, ins_left;
    vec_t v;

    //        ls   we   addr          wdata         strb  wt  rdata         we   strb  exp_data
    vt[0] = '{1'b0, 1'b0, 30'h0000100, 32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0, 4'h0, 32'hDEADBEEF};
    vt[1] = '{1'b1, 1'b1, 30'h0000020, 32'h12345678, 4'h3, 3, 32'hCAFEF00D, 1'b1, 4'h3, 32'h00000000};
    vt[2] = '{1'b1, 1'b0, 30'h3FFFFFFF, 32'h0,       4'h0, 1, 32'hA5A5A5A5, 1'b0, 4'h0, 32'hA5A5A5A5};
    vt[3] = '{1'b0, 1'b0, 30'h0000000, 32'h0,        4'h0, 2, 32'hFFFFFFFF, 1'b0, 4'h0, 32'hFFFFFFFF};
    vt[4] = '{1'b1, 1'b1, 30'h0000155, 32'h0,        4'hF, 0, 32'h11111111, 1'b1, 4'hF, 32'hA5A5A5A5};
    vt[5] = '{1'b1, 1'b0, 30'h0000001, 32'h0,        4'h0, 0, 32'h00000001, 1'b0, 4'h0, 32'h00000001};

    idle_inputs();
    rst = 1'b1;
    exp_ins = '0; exp_ls = '0;
    #12;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_res", 32'({bus.ins_res, bus.ls_res}), 32'd0);
    chk("rst_ins_data", bus.ins_data, 32'd0);
    chk("rst_ls_data", bus.ls_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_txn(vt[i]);

    // Cancel raised in the same cycle the fetch is granted.
    bus.ins_req = 1'b1; bus.ins_addr = 30'h208; bus.ins_cancel = 1'b1;
    @(posedge clk); #1;
    bus.ins_cancel = 1'b0; bus.ins_req = 1'b0;
    chk("cxg_mem_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h13579BDF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("cxg_no_res", 32'({bus.ins_res, bus.ls_res}), 32'd0);
    @(posedge clk); #1;
    chk_quiet("cxg_idle");

    // Cancel raised during WAIT: access completes, no response.
    bus.ins_req = 1'b1; bus.ins_addr = 30'h200;
    @(posedge clk); #1;
    chk("cxw_mem_req", 32'(bus.mem_req), 32'd1);
    bus.ins_cancel = 1'b1;
    @(posedge clk); #1;
    bus.ins_cancel = 1'b0; bus.ins_req = 1'b0;
    chk("cxw_still_req", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("cxw_no_res", 32'({bus.ins_res, bus.ls_res}), 32'd0);
    @(posedge clk); #1;
    chk_quiet("cxw_idle");

    // Cancel while the LSU holds the grant is ignored.
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 30'h10;
    @(posedge clk); #1;
    bus.ins_cancel = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h00000077;
    @(posedge clk); #1;
    bus.ins_cancel = 1'b0; bus.mem_ack = 1'b0;
    chk("cxl_ls_res", 32'(bus.ls_res), 32'd1);
    chk("cxl_ls_data", bus.ls_data, 32'h00000077);
    exp_ls = 32'h00000077;
    @(posedge clk); #1;
    bus.ls_req = 1'b0;

    v = '{1'b0, 1'b0, 30'h300, 32'h0, 4'h0, 0, 32'h0BADF00D, 1'b0, 4'h0, 32'h0BADF00D};
    do_txn(v);

    // Acknowledge while idle must be ignored.
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55555555;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk_quiet("spur1");
    @(posedge clk); #1;
    chk_quiet("spur2");
    chk("spur_ins_data", bus.ins_data, exp_ins);
    chk("spur_ls_data", bus.ls_data, exp_ls);

    // Both requesters, two requests each, from reset (last grant = fetch).
`ifdef MEM_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
    reset_pulse();
    ls_left = 2; ins_left = 2;
    bus.ins_req = 1'b1; bus.ins_addr = 30'h40;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 30'h80;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("conflict_addr", 32'(bus.mem_addr),
          exp_order[k] ? 32'(bus.ls_addr) : 32'(bus.ins_addr));
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA0000000 | 32'(k);
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      chk("conflict_grant", 32'({bus.ls_res, bus.ins_res}),
          exp_order[k] ? 32'd2 : 32'd1);
      if (bus.ls_res) begin
        ls_left--;
        if (ls_left == 0) bus.ls_req = 1'b0; else bus.ls_addr = 30'h84;
      end
      if (bus.ins_res) begin
        ins_left--;
        if (ins_left == 0) bus.ins_req = 1'b0; else bus.ins_addr = 30'h44;
      end
      @(posedge clk); #1;
    end
    bus.ins_req = 1'b0; bus.ls_req = 1'b0;

    // Reset in the middle of WAIT abandons the access.
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 30'h44;
    @(posedge clk); #1;
    chk("rmw_mem_req", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmw_mem_req0", 32'(bus.mem_req), 32'd0);
    chk("rmw_mem_addr0", 32'(bus.mem_addr), 32'd0);
    chk("rmw_mem_we0", 32'({bus.mem_we, bus.mem_wstrb}), 32'd0);
    chk("rmw_mem_wdata0", bus.mem_wdata, 32'd0);
    chk("rmw_res0", 32'({bus.ins_res, bus.ls_res}), 32'd0);
    chk("rmw_ins_data0", bus.ins_data, 32'd0);
    chk("rmw_ls_data0", bus.ls_data, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ins = '0; exp_ls = '0;
    chk_quiet("rmw_after");
    v = '{1'b1, 1'b0, 30'h44, 32'h0, 4'h0, 1, 32'h600DDA7A, 1'b0, 4'h0, 32'h600DDA7A};
    do_txn(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
